// File: rtl/uart_rx_fifo_pkg.sv
// uart_rx_fifo_pkg: shared widths for the UART RX byte buffer
package uart_rx_fifo_pkg;
  localparam int UART_BYTE_W          = 8;
  localparam int UART_RX_FIFO_ADDR_W  = 9;
  localparam int UART_RX_FIFO_LEVEL_W = UART_RX_FIFO_ADDR_W + 1;
  localparam int DROP_CNT_W           = 8;
endpackage

// File: rtl/uart_rx_byte_fifo_if.sv
// uart_rx_byte_fifo_if: byte push strobe from the UART RX core and pop handshake to the CPU reader
//   rx_data/rx_valid : upstream byte strobe
//   rd_req           : pop request
//   rd_data/rd_valid : popped byte and its one-cycle strobe
interface uart_rx_byte_fifo_if
  import uart_rx_fifo_pkg::*;
#(
  parameter int DATA_W = UART_BYTE_W
);
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rd_req;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  modport master (output rx_data, rx_valid, rd_req, input rd_data, rd_valid);
  modport slave  (input rx_data, rx_valid, rd_req, output rd_data, rd_valid);
endinterface

// File: rtl/uart_rx_fifo_ram.sv
// uart_rx_fifo_ram: simple dual-port RAM, one write port, one registered read port (1-cycle latency)
//   we/waddr/wdata : write port
//   re/raddr/rdata : read port; rdata holds its value when re=0
//   reset_n        : clears only the read register, the array is not reset
module uart_rx_fifo_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  // a same-address read and write returns the old word, which a full FIFO relies on
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/uart_rx_byte_fifo.sv
// uart_rx_byte_fifo: 512-byte buffer between the UART RX core and the CPU PIO port, with occupancy and drop tracking
//   clk, reset_n (async, active-low)
//   bus          : rx_data/rx_valid in, rd_req in, rd_data/rd_valid out
//   level        : registered occupancy 0..512 (feeds the PIO in_port); empty/full derived from it
//   overflow     : sticky drop flag; drop_cnt saturating drop count; clr_overflow clears both
//   peak_level   : high-water mark, clr_peak reloads it; only present with UART_RX_BYTE_FIFO_PEAK_EN,
//                  otherwise tied to 0
module uart_rx_byte_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter  int DATA_W  = UART_BYTE_W,
  parameter  int ADDR_W  = UART_RX_FIFO_ADDR_W,
  localparam int LEVEL_W = ADDR_W + 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  uart_rx_byte_fifo_if.slave    bus,
  input  logic                  clr_overflow,
  input  logic                  clr_peak,
  output logic [LEVEL_W-1:0]    level,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic [DROP_CNT_W-1:0] drop_cnt,
  output logic [LEVEL_W-1:0]    peak_level
);
  logic [ADDR_W-1:0]  wptr, rptr;
  logic [LEVEL_W-1:0] level_nxt;
  logic               pop, push, drop;
  assign empty = level == '0;
  assign full  = level == {1'b1, {ADDR_W{1'b0}}};
  // a pop frees a slot on the same edge, so a full FIFO still takes a byte alongside a pop
  assign pop       = bus.rd_req && !empty;
  assign push      = bus.rx_valid && (!full || pop);
  assign drop      = bus.rx_valid && full && !pop;
  assign level_nxt = level + LEVEL_W'(push) - LEVEL_W'(pop);
  uart_rx_fifo_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk    (clk),
    .reset_n(reset_n),
    .we     (push),
    .waddr  (wptr),
    .wdata  (bus.rx_data),
    .re     (pop),
    .raddr  (rptr),
    .rdata  (bus.rd_data)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wptr         <= '0;
      rptr         <= '0;
      level        <= '0;
      bus.rd_valid <= 1'b0;
      overflow     <= 1'b0;
      drop_cnt     <= '0;
    end else begin
      wptr         <= push ? wptr + 1'b1 : wptr;
      rptr         <= pop ? rptr + 1'b1 : rptr;
      level        <= level_nxt;
      bus.rd_valid <= pop;
      overflow     <= clr_overflow ? 1'b0 : (overflow || drop);
      drop_cnt     <= clr_overflow ? '0 : (drop && drop_cnt != '1) ? drop_cnt + 1'b1 : drop_cnt;
    end
`ifdef UART_RX_BYTE_FIFO_PEAK_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) peak_level <= '0;
    else peak_level <= (clr_peak || level_nxt > peak_level) ? level_nxt : peak_level;
`else
  logic unused_clr_peak;
  assign unused_clr_peak = clr_peak;
  assign peak_level      = '0;
`endif
endmodule
